usb_line_xcvr: RTL and testbench

//  Parametrised DP/DM line transceiver: next generation of the host-side line stage.
//  TX: frames a variable-length bitstream from the encoder into J/K symbols.

---
 rtl/usb_line_pkg.sv | 27 ++
 rtl/usb_line_if.sv | 32 +++
 rtl/usb_line_xcvr_rx.sv | 138 +++++++++++++
 rtl/usb_line_xcvr.sv | 122 ++++++++++++
 tb/tb_usb_line_xcvr.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/usb_line_pkg.sv
// Shared types for the DP/DM line transceiver: line states, FSM encodings, line decoder.
package usb_line_pkg;

  typedef enum logic [1:0] {LS_J, LS_K, LS_SE0, LS_SE1} line_state_e;

  typedef logic [1:0] tx_state_e;
  localparam tx_state_e T_IDLE = 2'd0;
  localparam tx_state_e T_DATA = 2'd1;
  localparam tx_state_e T_SE0  = 2'd2;
  localparam tx_state_e T_J    = 2'd3;

  typedef logic [1:0] rx_state_e;
  localparam rx_state_e R_IDLE   = 2'd0;
  localparam rx_state_e R_DATA   = 2'd1;
  localparam rx_state_e R_EOP    = 2'd2;
  localparam rx_state_e R_WAIT_J = 2'd3;

  function automatic line_state_e decode_line(input logic dp, input logic dm);
    case ({dp, dm})
      2'b10:   return LS_J;
      2'b01:   return LS_K;
      2'b00:   return LS_SE0;
      default: return LS_SE1;
    endcase
  endfunction

endpackage

// File: rtl/usb_line_if.sv
// Encoder/decoder handshake and DP/DM line signals; master is the transceiver side.
interface usb_line_if #(parameter int LEN_W = 8);
  logic             tx_start;
  logic [LEN_W-1:0] tx_len;
  logic             tx_bit;
  logic             tx_bit_req;
  logic             tx_busy;
  logic             tx_done;
  logic             rx_en;
  logic             rx_bit;
  logic             rx_valid;
  logic             rx_eop;
  logic             rx_err;
  logic             rx_timeout;
  logic             dp_r;
  logic             dm_r;
  logic             dp_w;
  logic             dm_w;
  logic             oe;

  modport master (
    input  tx_start, tx_len, tx_bit, rx_en, dp_r, dm_r,
    output tx_bit_req, tx_busy, tx_done, rx_bit, rx_valid, rx_eop, rx_err, rx_timeout,
           dp_w, dm_w, oe
  );

  modport slave (
    output tx_start, tx_len, tx_bit, rx_en, dp_r, dm_r,
    input  tx_bit_req, tx_busy, tx_done, rx_bit, rx_valid, rx_eop, rx_err, rx_timeout,
           dp_w, dm_w, oe
  );
endinterface

// File: rtl/usb_line_xcvr_rx.sv
// Receive-side packet tracker; outputs are Mealy so a K is reported in the cycle it appears.
module usb_line_rx
  import usb_line_pkg::*;
#(
  parameter int MAX_PKT_BITS = 128,
  parameter int LEN_W        = $clog2(MAX_PKT_BITS + 1),
  parameter int EOP_SE0      = 2,
  parameter int RX_TIMEOUT   = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic dp,
  input  logic dm,
  output logic rx_bit,
  output logic rx_valid,
  output logic rx_eop,
  output logic rx_err,
  output logic rx_timeout
);

  localparam logic [LEN_W-1:0] MAX_BITS = LEN_W'(MAX_PKT_BITS);
  localparam logic [LEN_W-1:0] SE0_MAX  = LEN_W'(EOP_SE0);
  localparam logic [LEN_W-1:0] TO_LIM   = LEN_W'(RX_TIMEOUT);

  line_state_e      line;
  rx_state_e        state, state_nx;
  logic [LEN_W-1:0] bit_cnt, bit_nx, bit_inc;
  logic [LEN_W-1:0] se0_cnt, se0_nx, se0_inc;
  logic [LEN_W-1:0] to_cnt, to_nx, to_inc;

  assign line = decode_line(dp, dm);

  // Counters hold at all-ones rather than wrapping.
  assign bit_inc = (bit_cnt == '1) ? bit_cnt : bit_cnt + LEN_W'(1);
  assign se0_inc = (se0_cnt == '1) ? se0_cnt : se0_cnt + LEN_W'(1);
  assign to_inc  = (to_cnt  == '1) ? to_cnt  : to_cnt  + LEN_W'(1);

  always_comb begin
    state_nx   = state;
    bit_nx     = bit_cnt;
    se0_nx     = se0_cnt;
    to_nx      = to_cnt;
    rx_bit     = 1'b0;
    rx_valid   = 1'b0;
    rx_eop     = 1'b0;
    rx_err     = 1'b0;
    rx_timeout = 1'b0;
    if (!active) begin
      state_nx = R_IDLE;
      bit_nx   = '0;
      se0_nx   = '0;
      to_nx    = '0;
    end else begin
      case (state)
        R_IDLE: begin
          if (line == LS_K) begin
            state_nx = R_DATA;
            rx_valid = 1'b1;
            rx_bit   = dp;
            bit_nx   = LEN_W'(1);
            to_nx    = '0;
          end else if (to_inc == TO_LIM) begin
            rx_timeout = 1'b1;
            to_nx      = '0;
          end else begin
            to_nx = to_inc;
          end
        end
        R_DATA: begin
          case (line)
            LS_J, LS_K: begin
              // A further bit after a full-length packet is an overrun.
              if (bit_cnt >= MAX_BITS) begin
                rx_err   = 1'b1;
                state_nx = R_WAIT_J;
              end else begin
                rx_valid = 1'b1;
                rx_bit   = dp;
                bit_nx   = bit_inc;
              end
            end
            LS_SE0: begin
              state_nx = R_EOP;
              se0_nx   = LEN_W'(1);
            end
            default: begin
              rx_err   = 1'b1;
              state_nx = R_WAIT_J;
            end
          endcase
        end
        R_EOP: begin
          case (line)
            LS_SE0: begin
              if (se0_inc > SE0_MAX) begin
                rx_err   = 1'b1;
                state_nx = R_WAIT_J;
              end else begin
                se0_nx = se0_inc;
              end
            end
            LS_J: begin
              rx_eop   = 1'b1;
              state_nx = R_IDLE;
              to_nx    = '0;
            end
            default: begin
              rx_err   = 1'b1;
              state_nx = R_WAIT_J;
            end
          endcase
        end
        default: begin
          if (line == LS_J) begin
            state_nx = R_IDLE;
            to_nx    = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= R_IDLE;
      bit_cnt <= '0;
      se0_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_nx;
      se0_cnt <= se0_nx;
      to_cnt  <= to_nx;
    end
  end

endmodule

// File: rtl/usb_line_xcvr.sv
// Host-side DP/DM line stage: TX framing FSM with EOP generation, plus the gated RX tracker.
module usb_line_xcvr
  import usb_line_pkg::*;
#(
  parameter int MAX_PKT_BITS = 128,
  parameter int LEN_W        = $clog2(MAX_PKT_BITS + 1),
  parameter int EOP_SE0      = 2,
  parameter int EOP_J        = 1,
  parameter int RX_TIMEOUT   = 18
) (
  input logic        clk,
  input logic        rst,
  usb_line_if.master bus
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_BITS);
  localparam logic [LEN_W-1:0] SE0_LEN = LEN_W'(EOP_SE0);
  localparam logic [LEN_W-1:0] J_LEN   = LEN_W'(EOP_J);

  tx_state_e        tx_state;
  logic [LEN_W-1:0] tx_cnt, tx_cnt_inc, tx_len_r, len_clamped;
  logic             tx_busy, rx_active;
  logic             dp_out, dm_out, oe_out, req_out;

  assign len_clamped = (bus.tx_len > MAX_LEN) ? MAX_LEN : bus.tx_len;
  assign tx_cnt_inc  = (tx_cnt == '1) ? tx_cnt : tx_cnt + LEN_W'(1);
  assign tx_busy     = (tx_state != T_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= T_IDLE;
      tx_cnt   <= '0;
      tx_len_r <= '0;
    end else begin
      case (tx_state)
        T_IDLE: begin
          if (bus.tx_start && (bus.tx_len != '0)) begin
            tx_state <= T_DATA;
            tx_cnt   <= '0;
            tx_len_r <= len_clamped;
          end
        end
        T_DATA: begin
          if (tx_cnt_inc == tx_len_r) begin
            tx_state <= T_SE0;
            tx_cnt   <= '0;
          end else begin
            tx_cnt <= tx_cnt_inc;
          end
        end
        T_SE0: begin
          if (tx_cnt_inc == SE0_LEN) begin
            tx_state <= T_J;
            tx_cnt   <= '0;
          end else begin
            tx_cnt <= tx_cnt_inc;
          end
        end
        default: begin
          if (tx_cnt_inc == J_LEN) begin
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
          end else begin
            tx_cnt <= tx_cnt_inc;
          end
        end
      endcase
    end
  end

  // Line drive follows the state register directly so a reset returns the bus to J at once.
  always_comb begin
    dp_out  = 1'b1;
    dm_out  = 1'b0;
    oe_out  = 1'b0;
    req_out = 1'b0;
    case (tx_state)
      T_DATA: begin
        dp_out  = bus.tx_bit;
        dm_out  = ~bus.tx_bit;
        oe_out  = 1'b1;
        req_out = 1'b1;
      end
      T_SE0: begin
        dp_out = 1'b0;
        dm_out = 1'b0;
        oe_out = 1'b1;
      end
      T_J: oe_out = 1'b1;
      default: ;
    endcase
  end

  assign bus.dp_w       = dp_out;
  assign bus.dm_w       = dm_out;
  assign bus.oe         = oe_out;
  assign bus.tx_bit_req = req_out;
  assign bus.tx_busy    = tx_busy;
  assign bus.tx_done    = (tx_state == T_J) && (tx_cnt_inc == J_LEN);

  // Receiver only listens when a reply is expected and we are not driving the line.
  assign rx_active = bus.rx_en && !tx_busy;

  usb_line_rx #(
    .MAX_PKT_BITS (MAX_PKT_BITS),
    .LEN_W        (LEN_W),
    .EOP_SE0      (EOP_SE0),
    .RX_TIMEOUT   (RX_TIMEOUT)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .active     (rx_active),
    .dp         (bus.dp_r),
    .dm         (bus.dm_r),
    .rx_bit     (bus.rx_bit),
    .rx_valid   (bus.rx_valid),
    .rx_eop     (bus.rx_eop),
    .rx_err     (bus.rx_err),
    .rx_timeout (bus.rx_timeout)
  );

endmodule

// File: tb/tb_usb_line_xcvr.sv
// Directed bench for usb_line_xcvr: TX framing, length clamp, RX packet/EOP/timeout/error, reset abort.
module tb_usb_line_xcvr;

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   oe_cnt, req_cnt, done_cnt;
  logic exp_dp, exp_dm;
  logic [1:0] seq3 [8];
  logic [1:0] seq5 [7];
  logic [7:0] v3, b3, e3;
  logic [6:0] v5, r5;

  usb_line_if #(.LEN_W(8)) bus();

  usb_line_xcvr dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic start, input logic [7:0] len, input logic bit_in,
                               input logic en, input logic [1:0] line);
    bus.tx_start = start;
    bus.tx_len   = len;
    bus.tx_bit   = bit_in;
    bus.rx_en    = en;
    {bus.dp_r, bus.dm_r} = line;
  endtask

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, LJ);
    #2 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_busy", bus.tx_busy, 1'b0);
    checkOutput("rst_oe", bus.oe, 1'b0);
    checkOutput("rst_dp", bus.dp_w, 1'b1);
    checkOutput("rst_dm", bus.dm_w, 1'b0);
    checkOutput("rst_req", bus.tx_bit_req, 1'b0);
    checkOutput("rst_done", bus.tx_done, 1'b0);
    checkOutput("rst_valid", bus.rx_valid, 1'b0);
    checkOutput("rst_timeout", bus.rx_timeout, 1'b0);
    nextCycle();
    rst = 1'b0;

    $display("[TB] test 1: 32-bit packet");
    applyStimulus(1'b1, 8'd32, 1'b0, 1'b0, LJ);
    #1 checkOutput("t1_busy_before", bus.tx_busy, 1'b0);
    oe_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      nextCycle();
      applyStimulus(1'b0, 8'd32, k[0], 1'b0, LJ);
      #1;
      if (k <= 32) begin
        exp_dp = k[0];
        exp_dm = ~k[0];
      end else if (k <= 34) begin
        exp_dp = 1'b0;
        exp_dm = 1'b0;
      end else begin
        exp_dp = 1'b1;
        exp_dm = 1'b0;
      end
      checkOutput("t1_dp", bus.dp_w, exp_dp);
      checkOutput("t1_dm", bus.dm_w, exp_dm);
      checkOutput("t1_req", bus.tx_bit_req, k <= 32);
      checkOutput("t1_done", bus.tx_done, k == 35);
      checkOutput("t1_busy", bus.tx_busy, k <= 35);
      if (bus.oe) oe_cnt++;
    end
    checkCount("t1_oe_cycles", oe_cnt, 35);

    $display("[TB] test 2: zero length and clamp");
    applyStimulus(1'b1, 8'd0, 1'b0, 1'b0, LJ);
    nextCycle();
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, LJ);
    #1 checkOutput("t2_len0_ignored", bus.tx_busy, 1'b0);
    applyStimulus(1'b1, 8'd200, 1'b1, 1'b0, LJ);
    nextCycle();
    applyStimulus(1'b0, 8'd200, 1'b1, 1'b0, LJ);
    req_cnt  = 0;
    done_cnt = 0;
    for (int k = 0; k < 140; k++) begin
      #1;
      if (bus.tx_bit_req) req_cnt++;
      if (bus.tx_done) done_cnt++;
      nextCycle();
    end
    checkCount("t2_clamp_data_cycles", req_cnt, 128);
    checkCount("t2_clamp_done", done_cnt, 1);
    checkOutput("t2_idle_after", bus.tx_busy, 1'b0);

    $display("[TB] test 3: received packet with EOP");
    seq3 = '{LK, LJ, LK, LK, LSE0, LSE0, LJ, LJ};
    v3 = 8'b0000_1111;
    b3 = 8'b0000_0010;
    e3 = 8'b0100_0000;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, seq3[i]);
      #1;
      checkOutput("t3_valid", bus.rx_valid, v3[i]);
      checkOutput("t3_bit", bus.rx_bit, b3[i]);
      checkOutput("t3_eop", bus.rx_eop, e3[i]);
      checkOutput("t3_err", bus.rx_err, 1'b0);
      nextCycle();
    end

    $display("[TB] test 4: reply timeout");
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, LJ);
    nextCycle();
    for (int n = 1; n <= 40; n++) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, LJ);
      #1 checkOutput("t4_timeout", bus.rx_timeout, (n == 18) || (n == 36));
      nextCycle();
    end

    $display("[TB] test 5: SE0 too long then recovery");
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, LJ);
    nextCycle();
    seq5 = '{LK, LJ, LSE0, LSE0, LSE0, LJ, LK};
    v5 = 7'b100_0011;
    r5 = 7'b001_0000;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, seq5[i]);
      #1;
      checkOutput("t5_valid", bus.rx_valid, v5[i]);
      checkOutput("t5_err", bus.rx_err, r5[i]);
      checkOutput("t5_eop", bus.rx_eop, 1'b0);
      nextCycle();
    end

    $display("[TB] test 6: reset mid packet");
    applyStimulus(1'b1, 8'd32, 1'b0, 1'b0, LJ);
    for (int k = 0; k < 11; k++) begin
      nextCycle();
      applyStimulus(1'b0, 8'd32, 1'b0, 1'b0, LJ);
    end
    #1 checkOutput("t6_in_data", bus.tx_bit_req, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_dp", bus.dp_w, 1'b1);
    checkOutput("t6_rst_dm", bus.dm_w, 1'b0);
    checkOutput("t6_rst_busy", bus.tx_busy, 1'b0);
    checkOutput("t6_rst_oe", bus.oe, 1'b0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b1, 8'd4, 1'b1, 1'b0, LJ);
    nextCycle();
    applyStimulus(1'b0, 8'd4, 1'b1, 1'b0, LJ);
    req_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      #1;
      checkOutput("t6_done", bus.tx_done, k == 7);
      checkOutput("t6_oe", bus.oe, k <= 7);
      if (bus.tx_bit_req) req_cnt++;
      nextCycle();
    end
    checkCount("t6_full_packet_bits", req_cnt, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
